// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit RISC CPU.
// Drives register_bank select/transfer/PC/ALU controls and the memory read/write handshake.
module control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR_OP,
  input  logic        mem_ready,
  output logic [3:0]  sel_ip,
  output logic [3:0]  sel_op,
  output logic        TRNSFR,
  output logic        en_pc,
  output logic        incpc,
  output logic        rstpc,
  output logic        ALUEN,
  output logic [2:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal,
  output logic        instr_done
);

  localparam logic [3:0] RegPc   = 4'd0;
  localparam logic [3:0] RegAr   = 4'd1;
  localparam logic [3:0] RegAlu  = 4'd2;
  localparam logic [3:0] RegIr   = 4'd3;
  localparam logic [3:0] RegD1   = 4'd4;
  localparam logic [3:0] RegD2   = 4'd5;
  localparam logic [3:0] RegR0   = 4'd6;
  localparam logic [3:0] RegRes2 = 4'd15;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpAlu   = 4'd1;
  localparam logic [3:0] OpLoad  = 4'd2;
  localparam logic [3:0] OpStore = 4'd3;
  localparam logic [3:0] OpMov   = 4'd4;
  localparam logic [3:0] OpJmp   = 4'd5;
  localparam logic [3:0] OpHalt  = 4'd15;

  typedef enum logic [3:0] {
    StRstPc,
    StFAr,
    StFMem,
    StFInc,
    StDecode,
    StED1,
    StED2,
    StExAlu,
    StWbAlu,
    StMAr,
    StMRd,
    StMWr,
    StExMov,
    StExJmp,
    StHalt
  } state_e;

  state_e state_q, state_d;

  logic [3:0] opcode;
  logic [3:0] rd_code, rs1_code, rs2_code;
  logic [2:0] func;

  // General registers R0..R7 occupy bank codes 6..13.
  assign opcode   = IR_OP[15:12];
  assign rd_code  = RegR0 + {1'b0, IR_OP[11:9]};
  assign rs1_code = RegR0 + {1'b0, IR_OP[8:6]};
  assign rs2_code = RegR0 + {1'b0, IR_OP[5:3]};
  assign func     = IR_OP[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRstPc;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_ip     = RegRes2;
    sel_op     = RegPc;
    TRNSFR     = 1'b0;
    en_pc      = 1'b0;
    incpc      = 1'b0;
    rstpc      = 1'b0;
    ALUEN      = 1'b0;
    alu_op     = 3'd0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;

    if (rst) begin
      state_d = StRstPc;
    end else begin
      case (state_q)
        StRstPc: begin
          sel_ip  = RegPc;
          rstpc   = 1'b1;
          en_pc   = 1'b1;
          state_d = StFAr;
        end
        StFAr: begin
          sel_op  = RegPc;
          sel_ip  = RegAr;
          state_d = StFMem;
        end
        StFMem: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            sel_ip  = RegIr;
            TRNSFR  = 1'b1;
            state_d = StFInc;
          end
        end
        StFInc: begin
          sel_ip  = RegPc;
          en_pc   = 1'b1;
          incpc   = 1'b1;
          state_d = StDecode;
        end
        StDecode: begin
          case (opcode)
            OpNop: begin
              instr_done = 1'b1;
              state_d    = StFAr;
            end
            OpAlu:            state_d = StED1;
            OpLoad, OpStore:  state_d = StMAr;
            OpMov:            state_d = StExMov;
            OpJmp:            state_d = StExJmp;
            OpHalt:           state_d = StHalt;
            default: begin
              // Undefined opcodes retire as NOP.
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = StFAr;
            end
          endcase
        end
        StED1: begin
          sel_op  = rs1_code;
          sel_ip  = RegD1;
          state_d = StED2;
        end
        StED2: begin
          sel_op  = rs2_code;
          sel_ip  = RegD2;
          state_d = StExAlu;
        end
        StExAlu: begin
          ALUEN   = 1'b1;
          alu_op  = func;
          state_d = StWbAlu;
        end
        StWbAlu: begin
          sel_op     = RegAlu;
          sel_ip     = rd_code;
          instr_done = 1'b1;
          state_d    = StFAr;
        end
        StMAr: begin
          sel_op  = rs1_code;
          sel_ip  = RegAr;
          state_d = (opcode == OpStore) ? StMWr : StMRd;
        end
        StMRd: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            sel_ip     = rd_code;
            TRNSFR     = 1'b1;
            instr_done = 1'b1;
            state_d    = StFAr;
          end
        end
        StMWr: begin
          // Keep rs2 on Dout for the whole request so memory sees stable write data.
          mem_wr = 1'b1;
          sel_op = rs2_code;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = StFAr;
          end
        end
        StExMov: begin
          sel_op     = rs1_code;
          sel_ip     = rd_code;
          instr_done = 1'b1;
          state_d    = StFAr;
        end
        StExJmp: begin
          sel_op     = rs1_code;
          sel_ip     = RegPc;
          en_pc      = 1'b1;
          instr_done = 1'b1;
          state_d    = StFAr;
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: begin
          state_d = StRstPc;
        end
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit RISC CPU. It sits directly upstream of `register_bank` and drives that block's write select, read select, transfer, PC-control and ALU-enable inputs. It also runs the external memory read/write handshake and decodes the instruction held in IR.

## Interface
Parameters: none. Register codes on `sel_ip`/`sel_op`: 0=PC, 1=AR, 2=ALUREG, 3=IR, 4=D1, 5=D2, 6..13=R0..R7, 14=DR, 15=RES2. RES2 is the scratch sink for cycles with no architectural write.
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- IR_OP  in  16  current instruction from the register bank
- mem_ready  in  1  memory completes the current read/write this cycle
- sel_ip  out  4  register bank write select
- sel_op  out  4  register bank read select
- TRNSFR  out  1  1 = write data from memory Din, 0 = from bank Dout
- en_pc  out  1  enable PC load path
- incpc  out  1  1 = PC loads PC+1
- rstpc  out  1  1 = PC loads 0
- ALUEN  out  1  ALUREG captures ALU_IN
- alu_op  out  3  ALU function, equal to IR_OP[2:0] in EX_ALU, else 0
- mem_rd, mem_wr  out  1  memory request strobes
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on undefined opcode
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] func.
- Opcodes:
  - 0 NOP
  - 1 ALU: rd <= f(rs1, rs2)
  - 2 LOAD: rd <= M[rs1]
  - 3 STORE: M[rs1] <= rs2
  - 4 MOV: rd <= rs1
  - 5 JMP: PC <= rs1
  - 15 HALT
  - 6..14 are illegal and execute as NOP with `illegal` pulsed in DECODE.
- Idle output values: sel_ip=15, sel_op=0, all strobes 0, alu_op=0. Every state drives idle values except where listed below.
- State sequence:
  - RSTPC: sel_ip=0, rstpc=1, en_pc=1 → F_AR.
  - F_AR: sel_op=0, sel_ip=1 (AR<=PC) → F_MEM.
  - F_MEM: mem_rd=1. If mem_ready: sel_ip=3, TRNSFR=1 (IR<=Din) → F_INC. Otherwise stay, with sel_ip=15.
  - F_INC: sel_ip=0, en_pc=1, incpc=1 → DECODE.
  - DECODE: no write; branches on opcode.
    - NOP/illegal: instr_done → F_AR.
    - HALT → HALT.
  - ALU path: E_D1 (sel_op=6+rs1, sel_ip=4) → E_D2 (sel_op=6+rs2, sel_ip=5) → EX_ALU (ALUEN=1, alu_op=func) → WB_ALU (sel_op=2, sel_ip=6+rd, instr_done) → F_AR.
  - LOAD path: M_AR (sel_op=6+rs1, sel_ip=1) → M_RD (mem_rd=1; on mem_ready sel_ip=6+rd, TRNSFR=1, instr_done → F_AR; otherwise stay).
  - STORE path: M_AR → M_WR (mem_wr=1, sel_op=6+rs2 so bank Dout carries the write data; on mem_ready instr_done → F_AR).
  - MOV: EX_MOV (sel_op=6+rs1, sel_ip=6+rd, instr_done) → F_AR.
  - JMP: EX_JMP (sel_op=6+rs1, sel_ip=0, en_pc=1, incpc=0, instr_done) → F_AR.
  - HALT: idle outputs, halted=1; stays until rst.
- Outputs other than `alu_op` and `illegal` are decoded from state. In F_MEM, M_RD and M_WR they are additionally qualified by `mem_ready`.

## Timing
- While rst=1: the state register loads RSTPC and all outputs are forced to idle values.
- After reset, the first rising edge with rst=0 executes RSTPC.
- Fetch takes 3 cycles plus memory wait cycles.
- Per-instruction latency with zero-wait memory, fetch included:
  - NOP: 4
  - MOV: 5
  - JMP: 5
  - LOAD: 6
  - STORE: 6
  - ALU: 8
- Memory handshake:
  - mem_rd/mem_wr rise on entry to the memory state and hold until the cycle in which mem_ready=1 is sampled.
  - They drop on the next edge.
  - mem_ready outside memory states is ignored.
  - mem_ready=1 in the first request cycle means zero wait states.
- rst asserted mid-instruction, including during a memory wait: the next edge goes to RSTPC, strobes drop immediately, and no partial write-back occurs.
- HALT with a pending mem_ready edge has no effect.
- ALUREG captures on the edge ending EX_ALU; WB_ALU reads the new value.
- rd=rs1 (MOV R3,R3) is legal and rewrites the same value.

## Test plan
- Reset then NOP at M[0], zero-wait memory → rstpc=1 in cycle 1; AR=0; IR=0x0000; PC=1 after F_INC; instr_done in cycle 5.
- R1=5, R2=7, instruction 0x1650 (ALU rd=3, rs1=1, rs2=2, func=0 add) → D1=5, D2=7, ALUEN for one cycle, R3=12, instr_done 8 cycles after F_AR.
- LOAD 0x2840 (rd=4, rs1=1, R1=0x0010) with mem_ready low for 3 cycles → mem_rd high for exactly 4 cycles, then R4=Din, TRNSFR=1 only in the capture cycle.
- STORE 0x3050 (rs1=1, rs2=2) → AR=R1; mem_wr high with sel_op=8 until mem_ready; no register changes besides AR and PC.
- JMP 0x5080 (rs1=2, R2=0x0020) → PC=0x0020; the next F_AR drives sel_op=0 and AR=0x0020. Opcode 0x7000 → illegal pulses once, PC advances by 1.
- HALT 0xF000 → halted stays 1 for 20 cycles with sel_ip=15. Separately, rst during an M_RD wait → mem_rd drops and the next state is RSTPC.
